// File: rtl/calc.sv
// 16-bit accumulator calculator: buttons pick an ALU operation, btnc applies
// acc <= acc OP sw on each rising edge, and the accumulator drives the LEDs.

package calc_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [3:0] {
    ALU_SRL  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_ADD  = 4'b0100,
    ALU_SUB  = 4'b0101,
    ALU_MULT = 4'b0110,
    ALU_NOR  = 4'b1010,
    ALU_NAND = 4'b1011,
    ALU_XOR  = 4'b1100
  } alu_op_e;

endpackage : calc_pkg

// Purely combinational 16-bit ALU; results are taken modulo 2^16.
module calc_alu
  import calc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] y
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  // NOTE: every output of an always_comb gets a default on entry so that no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    y = '0;
    unique case (op)
      // Amounts of 16..31 shift every bit out, so the result is zero.
      ALU_SRL:  y = shamt[4] ? '0 : (a >> shamt[3:0]);
      ALU_SLL:  y = shamt[4] ? '0 : (a << shamt[3:0]);
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_MULT: y = a * b;
      ALU_NOR:  y = ~(a | b);
      ALU_NAND: y = ~(a & b);
      ALU_XOR:  y = a ^ b;
      default:  y = '0;
    endcase
  end

endmodule : calc_alu

module calc
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              btnac,
  input  logic              btnc,
  input  logic              btnl,
  input  logic              btnr,
  input  logic              btnd,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] led
);

  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] acc_d;
  // Initial value gives the zero power-up state on FPGA targets before any reset.
  logic [DATA_W-1:0] acc_q = '0;

  always_comb begin
    alu_op = ALU_SRL;
    unique case ({btnl, btnr, btnd})
      3'b000: alu_op = ALU_SRL;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_ADD;
      3'b011: alu_op = ALU_SUB;
      3'b100: alu_op = ALU_MULT;
      3'b101: alu_op = ALU_NOR;
      3'b110: alu_op = ALU_NAND;
      3'b111: alu_op = ALU_XOR;
      default: alu_op = ALU_SRL;
    endcase
  end

  calc_alu u_alu (
    .a  (acc_q),
    .b  (sw),
    .op (alu_op),
    .y  (alu_y)
  );

  // Clear wins over execute; btnc is a plain level enable, one update per edge.
  always_comb begin
    acc_d = acc_q;
    if (btnac) begin
      acc_d = '0;
    end else if (btnc) begin
      acc_d = alu_y;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign led = acc_q;

endmodule : calc

// File: tb/tb_calc.sv
// Self-checking bench for calc: directed vector table, wrap/hold/level
// sequences, then randomized traffic against an arithmetic reference model.

module tb_calc;

  localparam logic [2:0] OP_SRL  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MULT = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NAND = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] sw;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        btnac, btnc, btnl, btnr, btnd;
  logic [15:0] sw;
  logic [15:0] led;

  int errors = 0;
  int checks = 0;

  calc dut (
    .clk   (clk),
    .btnac (btnac),
    .btnc  (btnc),
    .btnl  (btnl),
    .btnr  (btnr),
    .btnd  (btnd),
    .sw    (sw),
    .led   (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: led=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge happen, sample 1ns later.
  task automatic step(input logic [2:0] op, input logic [15:0] s,
                      input logic c, input logic ac);
    @(negedge clk);
    {btnl, btnr, btnd} = op;
    sw    = s;
    btnc  = c;
    btnac = ac;
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from the arithmetic definition of each operation.
  function automatic logic [15:0] ref_alu(input logic [2:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    longint x = longint'(a);
    longint y = longint'(b);
    longint r = 0;
    longint p = 1;
    int     amt = int'(b % 16'd32);
    for (int i = 0; i < amt; i++) p = p * 2;
    case (op)
      OP_SRL:  r = (amt >= 16) ? 0 : x / p;
      OP_SLL:  r = (x * p) % 65536;
      OP_ADD:  r = (x + y) % 65536;
      OP_SUB:  r = (x - y + 65536) % 65536;
      OP_MULT: r = (x * y) % 65536;
      OP_NOR:  r = 65535 - (x | y);
      OP_NAND: r = 65535 - (x & y);
      default: r = x ^ y;
    endcase
    return r[15:0];
  endfunction

  vec_t        vecs[8];
  logic [15:0] model_acc;
  logic [15:0] hold_val;
  logic [2:0]  rop;
  logic [15:0] rsw;
  logic        rc, rac;

  initial begin
    vecs[0] = '{OP_ADD,  16'h285a, 16'h285a};
    vecs[1] = '{OP_XOR,  16'h04c8, 16'h2c92};
    vecs[2] = '{OP_SRL,  16'h0005, 16'h0164};
    vecs[3] = '{OP_NOR,  16'ha085, 16'h5e1a};
    vecs[4] = '{OP_MULT, 16'h07fe, 16'h13cc};
    vecs[5] = '{OP_SLL,  16'h0004, 16'h3cc0};
    vecs[6] = '{OP_NAND, 16'hfa65, 16'hc7bf};
    vecs[7] = '{OP_SUB,  16'hb2e4, 16'h14db};

    btnac = 1'b0; btnc = 1'b0; btnl = 1'b0; btnr = 1'b0; btnd = 1'b0; sw = '0;
    #1;
    check("power_up", led, 16'h0000);

    // Reset, and reset held together with execute.
    step(OP_ADD, 16'h1111, 1'b1, 1'b0);
    check("pre_reset_add", led, 16'h1111);
    step(OP_SRL, 16'h0000, 1'b0, 1'b1);
    check("reset", led, 16'h0000);
    step(OP_ADD, 16'h1234, 1'b1, 1'b1);
    check("reset_over_exec_1", led, 16'h0000);
    step(OP_XOR, 16'hffff, 1'b1, 1'b1);
    check("reset_over_exec_2", led, 16'h0000);

    // Directed chain from acc=0.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].op, vecs[i].sw, 1'b1, 1'b0);
      check($sformatf("vec%0d", i), led, vecs[i].exp);
    end

    // Wrap-around and shift-range corners.
    step(OP_SRL, 16'h0000, 1'b0, 1'b1);
    step(OP_ADD, 16'hffff, 1'b1, 1'b0);
    check("load_ffff", led, 16'hffff);
    step(OP_ADD, 16'h0001, 1'b1, 1'b0);
    check("add_wrap", led, 16'h0000);
    step(OP_SUB, 16'h0001, 1'b1, 1'b0);
    check("sub_wrap", led, 16'hffff);
    step(OP_SRL, 16'h0000, 1'b0, 1'b1);
    step(OP_ADD, 16'h0001, 1'b1, 1'b0);
    step(OP_SLL, 16'h0010, 1'b1, 1'b0);
    check("sll_16", led, 16'h0000);
    step(OP_ADD, 16'h8000, 1'b1, 1'b0);
    step(OP_SRL, 16'h002f, 1'b1, 1'b0);
    check("srl_15_upper_ignored", led, 16'h0001);
    step(OP_SLL, 16'hffe3, 1'b1, 1'b0);
    check("sll_3_upper_ignored", led, 16'h0008);
    step(OP_ADD, 16'h7ff8, 1'b1, 1'b0);
    step(OP_SRL, 16'h0031, 1'b1, 1'b0);
    check("srl_17", led, 16'h0000);

    // Idle: inputs wiggle, accumulator must not move.
    step(OP_SRL, 16'h0000, 1'b0, 1'b1);
    step(OP_ADD, 16'h1234, 1'b1, 1'b0);
    hold_val = led;
    check("hold_load", hold_val, 16'h1234);
    for (int i = 0; i < 10; i++) begin
      step(3'($urandom_range(0, 7)), 16'($urandom), 1'b0, 1'b0);
      check($sformatf("hold%0d", i), led, 16'h1234);
    end

    // Level-sensitive execute: three edges, three additions.
    step(OP_SRL, 16'h0000, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      step(OP_ADD, 16'h0001, 1'b1, 1'b0);
      check($sformatf("level_edge%0d", i), led, 16'(i));
    end

    // Randomized traffic against the model.
    model_acc = 16'h0003;
    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom_range(0, 7));
      rsw = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      rc  = ($urandom_range(0, 9) < 7);
      rac = ($urandom_range(0, 19) == 0);
      step(rop, rsw, rc, rac);
      if (rac)     model_acc = 16'h0000;
      else if (rc) model_acc = ref_alu(rop, model_acc, rsw);
      check($sformatf("rand%0d op%0d", i, rop), led, model_acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_calc
